// File: rtl/mm_pkg.sv
// Shared types and defaults for the mm_pipe_buff skid-buffer pipeline.
package mm_pkg;

    localparam int MM_DATA_W = 1024;
    localparam int MM_SIZE_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Occupancy ranges over 0..2*stages, so it needs clog2(2*stages+1) bits.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/mm_skid_stage.sv
// One 2-entry skid buffer stage: main register feeds the output, skid register
// catches the beat that arrives while the output is stalled.
module mm_skid_stage
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        count
);

    stage_state_t      state_reg;
    stage_state_t      state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] skid_reg;
    logic              load_main;
    logic              load_skid;
    logic              skid_to_main;
    logic              in_fire;
    logic              out_fire;

    // Handshake flags come straight from the state register, so no
    // combinational path runs from out_ready to in_ready.
    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign count     = (state_reg == TWO) ? 2'd2 : (state_reg == ONE) ? 2'd1 : 2'd0;

    always_comb begin
        state_next   = state_reg;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        load_main  = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        state_next = TWO;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        skid_to_main = 1'b1;
                        state_next   = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (load_main) begin
                main_reg <= in_data;
            end else if (skid_to_main) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= in_data;
            end
        end
    end

endmodule

// File: rtl/mm_pipe_buff.sv
// Cascade of STAGES skid stages plus a fixed-latency sideband delay line.
// Optional beat counter output enabled by defining MM_PIPE_BUFF_STATS_EN.
module mm_pipe_buff
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W,
    parameter int SIZE_W = MM_SIZE_W,
    parameter int STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              data_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [DATA_W-1:0]              data_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    input  logic                           start_in,
    input  logic [SIZE_W-1:0]              size1_in,
    input  logic [SIZE_W-1:0]              size2_in,
    input  logic                           flush_in,
    output logic                           start_out,
    output logic [SIZE_W-1:0]              size1_out,
    output logic [SIZE_W-1:0]              size2_out,
    output logic                           flush_out,
    input  logic                           pull_in,
    output logic                           pull_out,
    output logic [occ_width(STAGES)-1:0]   occupancy
`ifdef MM_PIPE_BUFF_STATS_EN
    ,
    output logic [31:0]                    beat_cnt
`endif
);

    localparam int OCC_W = occ_width(STAGES);
    localparam int SB_W  = 2 * SIZE_W + 2;

    logic [DATA_W-1:0] link_data [STAGES+1];
    logic [STAGES:0]   link_valid;
    logic [STAGES:0]   link_ready;
    logic [1:0]        stage_cnt [STAGES];
    logic              alive_reg;
    logic [SB_W-1:0]   sb_reg [STAGES];
    logic [OCC_W-1:0]  occ_sum;

    // alive_reg holds ready_out low through reset and releases it on the first edge after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_reg <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
        end
    end

    assign link_data[0]       = data_in;
    assign link_valid[0]      = valid_in && alive_reg;
    assign link_ready[STAGES] = ready_in;
    assign ready_out          = alive_reg && link_ready[0];
    assign data_out           = link_data[STAGES];
    assign valid_out          = link_valid[STAGES];
    assign pull_out           = pull_in;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            mm_skid_stage #(
                .DATA_W(DATA_W)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush_in),
                .in_data   (link_data[gi]),
                .in_valid  (link_valid[gi]),
                .in_ready  (link_ready[gi]),
                .out_data  (link_data[gi+1]),
                .out_valid (link_valid[gi+1]),
                .out_ready (link_ready[gi+1]),
                .count     (stage_cnt[gi])
            );
        end
    endgenerate

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(stage_cnt[i]);
        end
    end
    assign occupancy = occ_sum;

    // Sideband advances every cycle regardless of backpressure or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            sb_reg[0] <= {start_in, flush_in, size1_in, size2_in};
            for (int i = 1; i < STAGES; i++) begin
                sb_reg[i] <= sb_reg[i-1];
            end
        end
    end

    assign start_out = sb_reg[STAGES-1][SB_W-1];
    assign flush_out = sb_reg[STAGES-1][SB_W-2];
    assign size1_out = sb_reg[STAGES-1][2*SIZE_W-1:SIZE_W];
    assign size2_out = sb_reg[STAGES-1][SIZE_W-1:0];

`ifdef MM_PIPE_BUFF_STATS_EN
    logic [31:0] beat_cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_reg <= '0;
        end else if (flush_in) begin
            beat_cnt_reg <= '0;
        end else if (valid_out && ready_in) begin
            beat_cnt_reg <= beat_cnt_reg + 32'd1;
        end
    end
    assign beat_cnt = beat_cnt_reg;
`endif

endmodule

// File: tb/tb_mm_pipe_buff.sv
// Directed/table-driven bench for mm_pipe_buff with default parameters (STAGES=2).
module tb_mm_pipe_buff;

    localparam int DW = 1024;
    localparam int SW = 64;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          start_in;
    logic [SW-1:0] size1_in;
    logic [SW-1:0] size2_in;
    logic          flush_in;
    logic          start_out;
    logic [SW-1:0] size1_out;
    logic [SW-1:0] size2_out;
    logic          flush_out;
    logic          pull_in;
    logic          pull_out;
    logic [2:0]    occupancy;
`ifdef MM_PIPE_BUFF_STATS_EN
    logic [31:0]   beat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    mm_pipe_buff dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .start_in  (start_in),
        .size1_in  (size1_in),
        .size2_in  (size2_in),
        .flush_in  (flush_in),
        .start_out (start_out),
        .size1_out (size1_out),
        .size2_out (size2_out),
        .flush_out (flush_out),
        .pull_in   (pull_in),
        .pull_out  (pull_out),
        .occupancy (occupancy)
`ifdef MM_PIPE_BUFF_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        rdy;
        logic        exp_vout;
        logic [31:0] exp_dout;
        logic        exp_rdy;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic vin, input logic [31:0] din, input logic rdy,
                                input logic ev, input logic [31:0] ed, input logic er,
                                input logic [2:0] eo);
        vec_t v;
        v.vin = vin; v.din = din; v.rdy = rdy;
        v.exp_vout = ev; v.exp_dout = ed; v.exp_rdy = er; v.exp_occ = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [31:0] d);
        valid_in = v;
        data_in  = '0;
        data_in[31:0] = d;
    endtask

    initial begin
        int sent;
        int recv;
        int cyc;
        int occ_bad;
        int stray;
        logic [31:0] exp_q[$];
        logic [31:0] exp_beat;

        rst = 1'b0; data_in = '0; valid_in = 1'b0; ready_in = 1'b0;
        start_in = 1'b0; size1_in = '0; size2_in = '0; flush_in = 1'b0; pull_in = 1'b0;

        // Reset state
        #1;
        check("rst_valid_out", DW'(valid_out), DW'(1'b0));
        check("rst_ready_out", DW'(ready_out), DW'(1'b0));
        check("rst_occupancy", DW'(occupancy), DW'(3'd0));
        check("rst_start_out", DW'(start_out), DW'(1'b0));
        check("rst_flush_out", DW'(flush_out), DW'(1'b0));
        check("rst_size1_out", DW'(size1_out), DW'(64'd0));
        check("rst_data_out", data_out, '0);
        tick(); tick();
        rst = 1'b1;
        check("rel_ready_before_edge", DW'(ready_out), DW'(1'b0));
        tick();
        check("rel_ready_after_edge", DW'(ready_out), DW'(1'b1));

        // Pull passthrough is combinational
        pull_in = 1'b1; #1;
        check("pull_high", DW'(pull_out), DW'(1'b1));
        pull_in = 1'b0; #1;
        check("pull_low", DW'(pull_out), DW'(1'b0));
        tick();

        // Steady flow: beats 1..8 back-to-back, out from cycle 2 through 9
        for (int c = 0; c <= 10; c++) begin
            tab.push_back(mk(c < 8, 32'(c + 1), 1'b1,
                             (c >= 2 && c <= 9), 32'(c - 1), 1'b1,
                             (c == 0 || c == 10) ? 3'd0 : (c == 1 || c == 9) ? 3'd1 : 3'd2));
        end
        // Full backpressure: four accepted, two held off until ready_in returns
        tab.push_back(mk(1, 32'h11, 0, 0, 32'h00, 1, 3'd0));
        tab.push_back(mk(1, 32'h12, 0, 0, 32'h00, 1, 3'd1));
        tab.push_back(mk(1, 32'h13, 0, 1, 32'h11, 1, 3'd2));
        tab.push_back(mk(1, 32'h14, 0, 1, 32'h11, 1, 3'd3));
        tab.push_back(mk(1, 32'h15, 0, 1, 32'h11, 0, 3'd4));
        tab.push_back(mk(1, 32'h15, 0, 1, 32'h11, 0, 3'd4));
        tab.push_back(mk(1, 32'h15, 1, 1, 32'h11, 0, 3'd4));
        tab.push_back(mk(1, 32'h15, 1, 1, 32'h12, 0, 3'd3));
        tab.push_back(mk(1, 32'h15, 1, 1, 32'h13, 1, 3'd2));
        tab.push_back(mk(1, 32'h16, 1, 1, 32'h14, 1, 3'd2));
        tab.push_back(mk(0, 32'h00, 1, 1, 32'h15, 1, 3'd2));
        tab.push_back(mk(0, 32'h00, 1, 1, 32'h16, 1, 3'd1));
        tab.push_back(mk(0, 32'h00, 1, 0, 32'h00, 1, 3'd0));

        for (int i = 0; i < tab.size(); i++) begin
            set_beat(tab[i].vin, tab[i].din);
            ready_in = tab[i].rdy;
            $display("vec %0d: vin=%0d din=%0h rdy=%0d -> vout=%0d dout=%0h rdy_out=%0d occ=%0d",
                     i, tab[i].vin, tab[i].din, tab[i].rdy, valid_out, data_out[31:0], ready_out, occupancy);
            check($sformatf("vec%0d_valid_out", i), DW'(valid_out), DW'(tab[i].exp_vout));
            check($sformatf("vec%0d_ready_out", i), DW'(ready_out), DW'(tab[i].exp_rdy));
            check($sformatf("vec%0d_occupancy", i), DW'(occupancy), DW'(tab[i].exp_occ));
            if (tab[i].exp_vout)
                check($sformatf("vec%0d_data_out", i), data_out, DW'(tab[i].exp_dout));
            tick();
        end
`ifdef MM_PIPE_BUFF_STATS_EN
        check("beat_cnt_after_tables", DW'(beat_cnt), DW'(32'd14));
`endif

        // Random ready_in, 1000 beats, scoreboard order check
        sent = 0; recv = 0; cyc = 0; occ_bad = 0;
        while (recv < 1000 && cyc < 20000) begin
            ready_in = (sent >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            set_beat(sent < 1000, 32'h1000 + 32'(sent));
            if (occupancy > 3'd4) occ_bad++;
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_beat", data_out, '1);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check($sformatf("rand_beat%0d", recv), data_out, DW'(exp_beat));
                end
                recv++;
            end
            if (valid_in && ready_out) begin
                exp_q.push_back(data_in[31:0]);
                sent++;
            end
            tick();
            cyc++;
        end
        set_beat(1'b0, 32'h0);
        check("rand_recv_count", DW'(recv), DW'(1000));
        check("rand_occ_never_above_4", DW'(occ_bad), DW'(0));
        tick(); tick();

        // Flush at occupancy 3 together with an offered beat
        ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_beat(1'b1, 32'h21 + 32'(c));
            tick();
        end
        check("flush_pre_occ", DW'(occupancy), DW'(3'd3));
        set_beat(1'b1, 32'h99);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        set_beat(1'b0, 32'h0);
        check("flush_occ", DW'(occupancy), DW'(3'd0));
        check("flush_valid_out", DW'(valid_out), DW'(1'b0));
        check("flush_ready_out", DW'(ready_out), DW'(1'b1));
        check("flush_out_t1", DW'(flush_out), DW'(1'b0));
        tick();
        check("flush_out_t2", DW'(flush_out), DW'(1'b1));
        tick();
        check("flush_out_t3", DW'(flush_out), DW'(1'b0));
        ready_in = 1'b1;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            if (valid_out) stray++;
            tick();
        end
        check("flush_beats_lost", DW'(stray), DW'(0));

        // Sideband delayed 2 cycles even under backpressure
        ready_in = 1'b0;
        start_in = 1'b1;
        size1_in = 64'h0000000400000004;
        size2_in = 64'h0000000000001234;
        tick();
        start_in = 1'b0; size1_in = '0; size2_in = '0;
        check("sb_start_t1", DW'(start_out), DW'(1'b0));
        tick();
        check("sb_start_t2", DW'(start_out), DW'(1'b1));
        check("sb_size1_t2", DW'(size1_out), DW'(64'h0000000400000004));
        check("sb_size2_t2", DW'(size2_out), DW'(64'h0000000000001234));
        tick();
        check("sb_start_t3", DW'(start_out), DW'(1'b0));

        // Asynchronous reset while full
        ready_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_beat(1'b1, 32'h41 + 32'(c));
            tick();
        end
        check("full_occ", DW'(occupancy), DW'(3'd4));
        check("full_ready_out", DW'(ready_out), DW'(1'b0));
        check("full_valid_out", DW'(valid_out), DW'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid_out", DW'(valid_out), DW'(1'b0));
        check("arst_occ", DW'(occupancy), DW'(3'd0));
        check("arst_ready_out", DW'(ready_out), DW'(1'b0));
        check("arst_data_out", data_out, '0);
        set_beat(1'b0, 32'h0);
        tick();
        rst = 1'b1;
        check("arst_rel_ready_before_edge", DW'(ready_out), DW'(1'b0));
        tick();
        check("arst_rel_ready_after_edge", DW'(ready_out), DW'(1'b1));
        check("arst_rel_occ", DW'(occupancy), DW'(3'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_pipe_buff.md
MM_PIPE_BUFF -- requirements
Module: mm_pipe_buff

Interface
REQ-001 SHALL have parameter DATA_W, default 1024, meaning data beat width in bits.
REQ-002 SHALL have parameter SIZE_W, default 64, meaning width of each matrix-size word.
REQ-003 SHALL have parameter STAGES, default 2, legal 1..4, meaning number of cascaded skid stages.
REQ-004 SHALL have port clk, input, 1, the single clock; all flops on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports data_in (input, DATA_W) and valid_in (input, 1), the upstream beat and its qualifier.
REQ-007 SHALL have port ready_out, output, 1, upstream may transfer when valid_in and ready_out are both high.
REQ-008 SHALL have ports data_out (output, DATA_W) and valid_out (output, 1), the downstream beat.
REQ-009 SHALL have port ready_in, input, 1, downstream accept.
REQ-010 SHALL have inputs start_in (1), size1_in (SIZE_W), size2_in (SIZE_W) and flush_in (1), and matching outputs start_out, size1_out, size2_out and flush_out.
REQ-011 SHALL have port pull_in, input, 1, and port pull_out, output, 1, the drain request passed through.
REQ-012 SHALL have port occupancy, output, clog2(2*STAGES+1), total beats held.

Function
REQ-013 Each stage SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO, using a main register and a skid register.
REQ-014 In EMPTY, an input transfer SHALL load main and go to ONE.
REQ-015 In ONE, input plus output transfer SHALL reload main and stay in ONE; input only SHALL load skid and go to TWO; output only SHALL go to EMPTY.
REQ-016 In TWO, an output transfer SHALL move skid to main and go to ONE; no input is accepted in TWO.
REQ-017 Stage valid SHALL equal (state != EMPTY); stage ready SHALL equal (state != TWO), taken directly from the state register with no combinational path from ready_in.
REQ-018 Beat latency SHALL be STAGES cycles from input transfer to valid_out when unblocked, with throughput of one beat per cycle.
REQ-019 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated under any ready_in pattern, except on flush.
REQ-020 start, size1, size2 and flush SHALL each be delayed exactly STAGES cycles and SHALL be independent of backpressure.
REQ-021 flush_in high SHALL set every stage to EMPTY on the next edge, discarding all held beats.
REQ-022 A beat presented in the same cycle as flush_in SHALL be discarded, and ready_out SHALL be 1 on the cycle after a flush.
REQ-023 pull_out SHALL equal pull_in combinationally, with zero latency.
REQ-024 occupancy SHALL equal the sum of per-stage entry counts, updated each edge, with range 0..2*STAGES.
REQ-025 When all stages are in TWO, ready_out SHALL be 0 and occupancy SHALL be 2*STAGES.

Reset
REQ-026 While rst is low, the block SHALL asynchronously force:
- all stages to EMPTY;
- valid_out=0, ready_out=0 and occupancy=0;
- start_out=0, flush_out=0, size1_out=0 and size2_out=0.
REQ-027 ready_out SHALL rise on the first edge after rst deasserts.
REQ-028 data_out SHALL be 0 after reset.
REQ-029 Reset asserted mid-transfer SHALL discard all beats, with no partial state surviving.

Configuration
REQ-030 With MM_PIPE_BUFF_STATS_EN defined, the block SHALL add output beat_cnt (32 bits), counting downstream transfers, wrapping at 2^32, and cleared by rst and flush_in.
REQ-031 Without MM_PIPE_BUFF_STATS_EN, there SHALL be no beat_cnt port and no counter logic.

Structure
REQ-032 Package mm_pkg SHALL hold:
- default DATA_W and SIZE_W;
- the stage-state enum (EMPTY, ONE, TWO);
- a function for the occupancy width.
REQ-033 Sub-module mm_skid_stage SHALL implement one stage; mm_pipe_buff SHALL instantiate STAGES copies in a generate loop, along with the sideband delay line.

Verification
REQ-034 Steady flow: STAGES=2, ready_in=1, beats 0x1..0x8 sent back-to-back -> data_out 0x1..0x8 on 8 consecutive cycles starting 2 cycles after the first transfer.
REQ-035 Full backpressure: ready_in=0, then 6 beats offered -> 4 accepted, ready_out=0 and occupancy=4; then ready_in=1 -> the 4 beats come out in order and the remaining 2 are then accepted.
REQ-036 Random ready_in at 50%, 1000 beats -> output sequence identical to input and occupancy never above 4.
REQ-037 Flush: occupancy=3, flush_in pulsed together with valid_in -> occupancy=0 next cycle, valid_out=0, that beat lost, and flush_out high 2 cycles later.
REQ-038 Sideband: start_in pulse with size1_in=0x0000000400000004 -> start_out and size1_out=0x0000000400000004 exactly 2 cycles later, even with ready_in=0.
REQ-039 Async reset with occupancy=4 -> valid_out, occupancy and ready_out all 0 immediately without a clock edge; ready_out=1 after the first edge following release.
